// File: rtl/alu_apb_pkg.sv
// alu_apb_pkg: shared opcodes, command-word field layout and FSM encoding
// for the APB ALU requester.
package alu_apb_pkg;
  localparam logic [3:0] OP_ADD1 = 4'd1;
  localparam logic [3:0] OP_ADD2 = 4'd2;
  localparam logic [3:0] OP_ADD3 = 4'd3;
  localparam logic [3:0] OP_SHIFT = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR = 4'd6;
  localparam logic [3:0] OP_NAND = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd8;
  localparam logic [3:0] OP_COMP = 4'd9;
  localparam int OPC_LSB = 28;
  localparam int SHIFT_LSB = 26;
  localparam int CONST_LSB = 22;
  localparam int OP2_LSB = 14;
  localparam int OP1_LSB = 6;
  localparam int DEST_LSB = 0;
  localparam int DEST_W = 6;
  localparam int RESULT_REGS = 16;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_SETUP,
    S_WR_ACCESS,
    S_WAIT,
    S_RD_SETUP,
    S_RD_ACCESS,
    S_RESP
  } state_t;
endpackage

// File: rtl/apb_alu_cmd_pack.sv
// apb_alu_cmd_pack: packs the local command fields into the 32-bit ALU command word.
module apb_alu_cmd_pack
  import alu_apb_pkg::*;
(
  input  logic [3:0]  i_opcode,
  input  logic [1:0]  i_shift,
  input  logic [3:0]  i_const,
  input  logic [7:0]  i_op2,
  input  logic [7:0]  i_op1,
  input  logic [5:0]  i_dest,
  output logic [31:0] o_word
);
  assign o_word = (32'(i_opcode) << OPC_LSB) | (32'(i_shift) << SHIFT_LSB)
                | (32'(i_const) << CONST_LSB) | (32'(i_op2) << OP2_LSB)
                | (32'(i_op1) << OP1_LSB) | (32'(i_dest) << DEST_LSB);
endmodule

// File: rtl/apb_alu_requester.sv
// apb_alu_requester: writes one packed ALU command over APB, waits, reads the result back.
// Define APB_TIMEOUT_EN to abort ACCESS phases that see no pready within TIMEOUT_CYCLES.
module apb_alu_requester
  import alu_apb_pkg::*;
#(
  parameter logic [31:0] CMD_ADDR = 32'd0,
  parameter int COMPUTE_WAIT = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_opcode,
  input  logic [7:0]  cmd_op1,
  input  logic [7:0]  cmd_op2,
  input  logic [3:0]  cmd_const,
  input  logic [1:0]  cmd_shift,
  input  logic [5:0]  cmd_dest,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [8:0]  rsp_result,
  output logic        rsp_err,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);
  localparam int CW = $clog2(COMPUTE_WAIT + 1);
  state_t r_state, w_next;
  logic [31:0] r_word, w_word;
  logic [CW-1:0] r_cnt;
  logic [8:0] r_result;
  logic r_err;
  logic w_bad_dest, w_access, w_wr, w_rd, w_timeout, w_unused;
  apb_alu_cmd_pack u_pack (
    .i_opcode(cmd_opcode),
    .i_shift (cmd_shift),
    .i_const (cmd_const),
    .i_op2   (cmd_op2),
    .i_op1   (cmd_op1),
    .i_dest  (cmd_dest),
    .o_word  (w_word)
  );
  assign w_unused = ^prdata[31:9];
  assign w_bad_dest = r_word[DEST_W-1:0] > DEST_W'(RESULT_REGS - 1);
  assign w_access = r_state == S_WR_ACCESS || r_state == S_RD_ACCESS;
  assign w_wr = r_state == S_WR_SETUP || r_state == S_WR_ACCESS;
  assign w_rd = r_state == S_RD_SETUP || r_state == S_RD_ACCESS;
`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tcnt;
  assign w_timeout = w_access && !pready && r_tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (reset) r_tcnt <= '0;
    else r_tcnt <= w_access ? r_tcnt + 1'b1 : '0;
`else
  assign w_timeout = 1'b0;
`endif
  always_ff @(posedge clk)
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      w_next = cmd_valid ? S_WR_SETUP : S_IDLE;
      S_WR_SETUP:  w_next = S_WR_ACCESS;
      S_WR_ACCESS: w_next = w_timeout ? S_RESP : !pready ? S_WR_ACCESS : w_bad_dest ? S_RESP : S_WAIT;
      S_WAIT:      w_next = r_cnt == CW'(COMPUTE_WAIT - 1) ? S_RD_SETUP : S_WAIT;
      S_RD_SETUP:  w_next = S_RD_ACCESS;
      S_RD_ACCESS: w_next = pready || w_timeout ? S_RESP : S_RD_ACCESS;
      S_RESP:      w_next = rsp_ready ? S_IDLE : S_RESP;
      default:     w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_word <= '0;
      r_cnt <= '0;
      r_result <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= r_state == S_WAIT ? r_cnt + 1'b1 : '0;
      if (r_state == S_IDLE && cmd_valid) begin
        r_word <= w_word;
        r_result <= '0;
        r_err <= 1'b0;
      end
      if (r_state == S_WR_ACCESS && pready) r_err <= r_err | pslverr | w_bad_dest;
      if (r_state == S_RD_ACCESS && pready) begin
        r_result <= prdata[8:0];
        r_err <= r_err | pslverr;
      end
      if (w_timeout) begin
        r_result <= '0;
        r_err <= 1'b1;
      end
    end
  always_comb begin
    cmd_ready = r_state == S_IDLE && !reset;
    psel = w_wr || w_rd;
    penable = w_access;
    pwrite = w_wr;
    paddr = w_wr ? CMD_ADDR : w_rd ? {26'b0, r_word[DEST_W-1:0]} : 32'd0;
    pwdata = w_wr ? r_word : 32'd0;
    rsp_valid = r_state == S_RESP;
    rsp_result = r_state == S_RESP ? r_result : 9'd0;
    rsp_err = r_state == S_RESP && r_err;
  end
endmodule
